// File: rtl/snn_noc_pkg.sv
// rtl/snn_noc_pkg.sv - shared constants and FSM encoding for the spike packet accumulator
package snn_noc_pkg;

    localparam int ADDR_W  = 12;
    localparam int SRC_MSB = 2*ADDR_W-1;
    localparam int SRC_LSB = ADDR_W;
    localparam int DST_MSB = ADDR_W-1;
    localparam int DST_LSB = 0;

    localparam int ACC_W = 24;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ACCUM = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - synchronous packet FIFO allowing push and pop together when full
module packet_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head slot is freed in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/spike_packet_accumulator.sv
// rtl/spike_packet_accumulator.sv - matches spike packets to synapse weights and accumulates per neuron
module spike_packet_accumulator #(
    parameter int                NUM_NEURONS = 10,
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h000,
    parameter int                NUM_SYN     = 30,
    parameter int                WEIGHT_W    = 16,
    parameter int                ACC_W       = 24,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         reset_n,
    input  logic [2*ADDR_W-1:0]          pkt_in,
    input  logic                         pkt_valid,
    output logic                         pkt_ready,
    input  logic                         cfg_we,
    input  logic [4:0]                   cfg_idx,
    input  logic [ADDR_W-1:0]            cfg_src,
    input  logic [ADDR_W-1:0]            cfg_dst,
    input  logic [WEIGHT_W-1:0]          cfg_weight,
    input  logic                         cfg_valid,
    input  logic                         ts_end,
    output logic                         ts_done,
    output logic [NUM_NEURONS*ACC_W-1:0] acc_flat,
    output logic [15:0]                  miss_count,
    output logic [15:0]                  drop_count
);
    import snn_noc_pkg::*;

    localparam int               PW      = 2*ADDR_W;
    localparam int               NIDX_W  = $clog2(NUM_NEURONS);
    localparam logic [4:0]       LAST_K  = 5'(NUM_SYN-1);
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t              state, next_state;
    logic [PW-1:0]       fifo_dout;
    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic                ts_pending;
    logic [PW-1:0]       cur_pkt;
    logic [NIDX_W-1:0]   cur_idx;
    logic [WEIGHT_W-1:0] cur_w;
    logic [4:0]          k;
    logic [ADDR_W-1:0]   pop_off;
    logic                pop_local;
    logic                hit;
    logic                flush_go;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    sat_sum;

    logic [NUM_SYN-1:0]  tbl_valid;
    logic [ADDR_W-1:0]   tbl_src [NUM_SYN];
    logic [ADDR_W-1:0]   tbl_dst [NUM_SYN];
    logic [WEIGHT_W-1:0] tbl_w   [NUM_SYN];
    logic [ACC_W-1:0]    acc     [NUM_NEURONS];

    // Packets are held off while a timestep close is pending so they land in the next snapshot.
    assign pkt_ready = reset_n & ~fifo_full & ~ts_pending;
    assign push      = pkt_valid & pkt_ready;
    assign pop_off   = fifo_dout[ADDR_W-1:0] - BASE_ADDR;
    assign pop_local = (pop_off < ADDR_W'(NUM_NEURONS));
    assign flush_go  = ts_pending & fifo_empty;
    assign hit       = tbl_valid[k] && (tbl_src[k] == cur_pkt[PW-1:ADDR_W])
                                    && (tbl_dst[k] == cur_pkt[ADDR_W-1:0]);

    packet_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLK),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pkt_in),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Saturating add of the sign-extended latched weight into the addressed accumulator.
    always_comb begin
        sum = {acc[cur_idx][ACC_W-1], acc[cur_idx]}
            + {{(ACC_W+1-WEIGHT_W){cur_w[WEIGHT_W-1]}}, cur_w};
        if (sum[ACC_W] != sum[ACC_W-1]) sat_sum = sum[ACC_W] ? SAT_MIN : SAT_MAX;
        else                            sat_sum = sum[ACC_W-1:0];
    end

    // State register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state, FIFO pop and timestep-done strobe.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        ts_done    = 1'b0;
        case (state)
            IDLE: begin
                if (flush_go) begin
                    next_state = FLUSH;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (pop_local) next_state = SCAN;
                end
            end
            SCAN: begin
                if (hit)              next_state = ACCUM;
                else if (k == LAST_K) next_state = IDLE;
            end
            ACCUM:   next_state = IDLE;
            FLUSH: begin
                ts_done    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Synapse table payload; only the valid bits need a reset value.
    always_ff @(posedge CLK) begin
        if (cfg_we && cfg_idx <= LAST_K) begin
            tbl_src[cfg_idx] <= cfg_src;
            tbl_dst[cfg_idx] <= cfg_dst;
            tbl_w[cfg_idx]   <= cfg_weight;
        end
    end

    // Synapse table valid bits.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) tbl_valid <= '0;
        else if (cfg_we && cfg_idx <= LAST_K) tbl_valid[cfg_idx] <= cfg_valid;
    end

    // Current packet, scan index, weight latch, event counters and timestep-pending flag.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cur_pkt    <= '0;
            cur_idx    <= '0;
            cur_w      <= '0;
            k          <= '0;
            ts_pending <= 1'b0;
            miss_count <= '0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                cur_pkt <= fifo_dout;
                cur_idx <= pop_off[NIDX_W-1:0];
                k       <= '0;
                if (!pop_local && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end
            if (state == SCAN) begin
                if (hit) begin
                    cur_w <= tbl_w[k];
                end else if (k == LAST_K) begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
            if (state == FLUSH)  ts_pending <= 1'b0;
            else if (ts_end)     ts_pending <= 1'b1;
        end
    end

    // Accumulators plus snapshot; the snapshot is captured on entry to FLUSH so it is valid with ts_done.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            acc_flat <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (state == IDLE && flush_go) acc_flat[i*ACC_W +: ACC_W] <= acc[i];
                if (state == FLUSH)                                    acc[i] <= '0;
                else if (state == ACCUM && cur_idx == NIDX_W'(i))      acc[i] <= sat_sum;
            end
        end
    end

endmodule
